// File: rtl/proc_io_hub.sv
// I/O hub between the core_fx I/O pins and external valid/ready streams:
// one FWFT FIFO per input and per output channel, with stall or sticky-error handling.
module proc_io_hub #(
  parameter int NUBITS   = 16,
  parameter int NUIOIN   = 8,
  parameter int NUIOOU   = 8,
  parameter int FDEPTH   = 4,
  parameter int BLOCKING = 1,
  localparam int AIW     = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
  localparam int AOW     = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_in,
  input  logic [AIW-1:0]           addr_in,
  output logic [NUBITS-1:0]        io_in,
  input  logic                     out_en,
  input  logic [AOW-1:0]           addr_out,
  input  logic [NUBITS-1:0]        io_out,
  output logic                     stall,
  input  logic [NUIOIN*NUBITS-1:0] s_data,
  input  logic [NUIOIN-1:0]        s_valid,
  output logic [NUIOIN-1:0]        s_ready,
  output logic [NUIOOU*NUBITS-1:0] m_data,
  output logic [NUIOOU-1:0]        m_valid,
  input  logic [NUIOOU-1:0]        m_ready,
  output logic [2:0]               err,
  input  logic                     err_clr
);

  localparam int  PW      = $clog2(FDEPTH);
  localparam int  CW      = PW + 1;
  localparam int  IN_SLOT = 1 << AIW;
  localparam int  OU_SLOT = 1 << AOW;
  localparam logic BLK    = (BLOCKING != 0);

  logic [NUBITS-1:0] in_head [NUIOIN];
  logic [NUIOIN-1:0] in_empty;
  logic [NUIOIN-1:0] in_full;
  logic [NUIOOU-1:0] out_empty;
  logic [NUIOOU-1:0] out_full;

  logic           rd_oob, wr_oob;
  logic           rd_hit, wr_hit;
  logic           rd_empty, wr_full;
  logic           rd_pop, wr_push;
  logic           rd_stall, wr_stall;
  logic [AIW-1:0] rd_idx;
  logic [AOW-1:0] wr_idx;
  logic [2:0]     err_set;

  // Address decode: out-of-range only exists when the channel count is not a power of two.
  assign rd_oob = (IN_SLOT != NUIOIN) && (int'(addr_in) >= NUIOIN);
  assign wr_oob = (OU_SLOT != NUIOOU) && (int'(addr_out) >= NUIOOU);
  assign rd_idx = rd_oob ? '0 : addr_in;
  assign wr_idx = wr_oob ? '0 : addr_out;

  assign rd_hit   = req_in && !rd_oob;
  assign wr_hit   = out_en && !wr_oob;
  // Occupancy is sampled before this edge's push/pop, so same-cycle traffic never bypasses.
  assign rd_empty = in_empty[rd_idx];
  assign wr_full  = out_full[wr_idx];
  assign rd_pop   = rd_hit && !rd_empty;
  assign wr_push  = wr_hit && !wr_full;
  assign rd_stall = BLK && rd_hit && rd_empty;
  assign wr_stall = BLK && wr_hit && wr_full;

  assign stall = rd_stall || wr_stall;
  assign io_in = rd_pop ? in_head[rd_idx] : '0;

  assign err_set[0] = !BLK && rd_hit && rd_empty;
  assign err_set[1] = !BLK && wr_hit && wr_full;
  assign err_set[2] = (req_in && rd_oob) || (out_en && wr_oob);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= '0;
    end else begin
      err <= (err_clr ? 3'b000 : err) | err_set;
    end
  end

  // Input channels: external producer pushes, core pops.
  for (genvar c = 0; c < NUIOIN; c++) begin : g_in
    logic [NUBITS-1:0] mem [FDEPTH];
    logic [PW-1:0]     wp, rp;
    logic [CW-1:0]     cnt;
    logic              push, pop;

    assign in_empty[c] = (cnt == '0);
    assign in_full[c]  = (cnt == CW'(FDEPTH));
    assign s_ready[c]  = !in_full[c];
    assign push        = s_valid[c] && !in_full[c];
    assign pop         = rd_pop && (rd_idx == AIW'(c));
    assign in_head[c]  = mem[rp];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= wp + PW'(1);
        if (pop)  rp <= rp + PW'(1);
        if (push && !pop)      cnt <= cnt + CW'(1);
        else if (pop && !push) cnt <= cnt - CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wp] <= s_data[c*NUBITS +: NUBITS];
    end
  end

  // Output channels: core pushes, external consumer pops.
  for (genvar c = 0; c < NUIOOU; c++) begin : g_out
    logic [NUBITS-1:0] mem [FDEPTH];
    logic [PW-1:0]     wp, rp;
    logic [CW-1:0]     cnt;
    logic              push, pop;

    assign out_empty[c] = (cnt == '0);
    assign out_full[c]  = (cnt == CW'(FDEPTH));
    assign m_valid[c]   = !out_empty[c];
    assign m_data[c*NUBITS +: NUBITS] = out_empty[c] ? '0 : mem[rp];
    assign push         = wr_push && (wr_idx == AOW'(c));
    assign pop          = m_valid[c] && m_ready[c];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= wp + PW'(1);
        if (pop)  rp <= rp + PW'(1);
        if (push && !pop)      cnt <= cnt + CW'(1);
        else if (pop && !push) cnt <= cnt - CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wp] <= io_out;
    end
  end

endmodule

// File: tb/tb_proc_io_hub.sv
// Directed bench for proc_io_hub: a default blocking instance and a
// non-blocking instance with six channels (non-power-of-two addressing).
module tb_proc_io_hub;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Instance A: defaults (8/8 channels, FDEPTH 4, BLOCKING 1)
  logic         a_req_in, a_out_en, a_stall, a_err_clr;
  logic [2:0]   a_addr_in, a_addr_out, a_err;
  logic [15:0]  a_io_in, a_io_out;
  logic [127:0] a_s_data, a_m_data;
  logic [7:0]   a_s_valid, a_s_ready, a_m_valid, a_m_ready;

  proc_io_hub u_a (
    .clk(clk), .rst(rst),
    .req_in(a_req_in), .addr_in(a_addr_in), .io_in(a_io_in),
    .out_en(a_out_en), .addr_out(a_addr_out), .io_out(a_io_out),
    .stall(a_stall),
    .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready),
    .err(a_err), .err_clr(a_err_clr)
  );

  // Instance B: 6/6 channels, non-blocking
  logic        b_req_in, b_out_en, b_stall, b_err_clr;
  logic [2:0]  b_addr_in, b_addr_out, b_err;
  logic [15:0] b_io_in, b_io_out;
  logic [95:0] b_s_data, b_m_data;
  logic [5:0]  b_s_valid, b_s_ready, b_m_valid, b_m_ready;

  proc_io_hub #(.NUIOIN(6), .NUIOOU(6), .BLOCKING(0)) u_b (
    .clk(clk), .rst(rst),
    .req_in(b_req_in), .addr_in(b_addr_in), .io_in(b_io_in),
    .out_en(b_out_en), .addr_out(b_addr_out), .io_out(b_io_out),
    .stall(b_stall),
    .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .err(b_err), .err_clr(b_err_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] wr_words [5];
  logic [15:0] rd_words [4];

  initial begin
    wr_words = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};
    a_req_in = 0; a_addr_in = 0; a_out_en = 0; a_addr_out = 0; a_io_out = 0;
    a_s_data = '0; a_s_valid = 0; a_m_ready = 0; a_err_clr = 0;
    b_req_in = 0; b_addr_in = 0; b_out_en = 0; b_addr_out = 0; b_io_out = 0;
    b_s_data = '0; b_s_valid = 0; b_m_ready = 0; b_err_clr = 0;

    // Reset state
    #2;
    check_eq("rst_s_ready", 32'(a_s_ready), 32'hFF);
    check_eq("rst_m_valid", 32'(a_m_valid), 32'h00);
    check_eq("rst_err", 32'(a_err), 32'h0);
    check_eq("rst_stall", 32'(a_stall), 32'h0);
    check_eq("rst_io_in", 32'(a_io_in), 32'h0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Reset mid-traffic discards buffered words
    a_s_valid = 8'h01; a_s_data[15:0] = 16'h1234;
    a_out_en = 1; a_addr_out = 3'd5; a_io_out = 16'hBEEF;
    tick();
    a_s_valid = 0; a_out_en = 0;
    #1;
    check_eq("pre_rst_m_valid", 32'(a_m_valid), 32'h20);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_s_ready", 32'(a_s_ready), 32'hFF);
    check_eq("mid_rst_m_valid", 32'(a_m_valid), 32'h00);
    check_eq("mid_rst_m_data5", 32'(a_m_data[5*16 +: 16]), 32'h0);
    check_eq("mid_rst_err", 32'(a_err), 32'h0);
    tick();
    rst = 1'b1;
    a_req_in = 1; a_addr_in = 3'd0;
    #1;
    check_eq("lost_word_stall", 32'(a_stall), 32'h1);
    check_eq("lost_word_io_in", 32'(a_io_in), 32'h0);
    tick();
    a_req_in = 0;

    // Push on ch3, read it the next cycle
    a_s_valid = 8'h08; a_s_data[3*16 +: 16] = 16'h00A5;
    tick();
    a_s_valid = 0;
    a_req_in = 1; a_addr_in = 3'd3;
    #1;
    check_eq("ch3_io_in", 32'(a_io_in), 32'h00A5);
    check_eq("ch3_stall", 32'(a_stall), 32'h0);
    tick();
    #1;
    check_eq("ch3_empty_stall", 32'(a_stall), 32'h1);
    check_eq("ch3_empty_io_in", 32'(a_io_in), 32'h0);
    a_req_in = 0;
    tick();

    // Blocking write: fill ch2, 5th write stalls until one word drains
    a_out_en = 1; a_addr_out = 3'd2;
    for (int i = 0; i < 4; i++) begin
      a_io_out = wr_words[i];
      #1;
      check_eq($sformatf("wr%0d_stall", i), 32'(a_stall), 32'h0);
      tick();
    end
    a_io_out = wr_words[4];
    #1;
    check_eq("wr4_stall", 32'(a_stall), 32'h1);
    check_eq("wr_full_m_valid", 32'(a_m_valid), 32'h04);
    tick();
    a_m_ready = 8'h04;
    #1;
    check_eq("wr4_stall_pop", 32'(a_stall), 32'h1);
    check_eq("wr_head0", 32'(a_m_data[2*16 +: 16]), 32'h0011);
    tick();
    a_m_ready = 0;
    #1;
    check_eq("wr4_unstall", 32'(a_stall), 32'h0);
    check_eq("wr_head1", 32'(a_m_data[2*16 +: 16]), 32'h0022);
    tick();
    a_out_en = 0;
    a_m_ready = 8'h04;
    for (int i = 1; i < 5; i++) begin
      #1;
      check_eq($sformatf("drain%0d", i), 32'(a_m_data[2*16 +: 16]), 32'(wr_words[i]));
      tick();
    end
    check_eq("drain_m_valid", 32'(a_m_valid), 32'h00);
    a_m_ready = 0;

    // Fill ch0, pop with a push offered in the same cycle, order kept across wrap
    for (int i = 1; i <= 4; i++) begin
      a_s_valid = 8'h01; a_s_data[15:0] = 16'(i);
      tick();
    end
    a_s_data[15:0] = 16'd5;
    a_req_in = 1; a_addr_in = 3'd0;
    #1;
    check_eq("ch0_full_ready", 32'(a_s_ready[0]), 32'h0);
    check_eq("ch0_rd1", 32'(a_io_in), 32'h1);
    tick();
    a_req_in = 0;
    #1;
    check_eq("ch0_ready_after_pop", 32'(a_s_ready[0]), 32'h1);
    tick();
    a_s_valid = 0;
    rd_words = '{16'd2, 16'd3, 16'd4, 16'd5};
    a_req_in = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("ch0_rd%0d", i + 2), 32'(a_io_in), 32'(rd_words[i]));
      tick();
    end
    #1;
    check_eq("ch0_empty_stall", 32'(a_stall), 32'h1);
    a_req_in = 0;
    tick();

    // Non-blocking underflow, clear, and set-wins-over-clear
    b_req_in = 1; b_addr_in = 3'd1;
    #1;
    check_eq("nb_uf_io_in", 32'(b_io_in), 32'h0);
    check_eq("nb_uf_stall", 32'(b_stall), 32'h0);
    tick();
    b_req_in = 0;
    check_eq("nb_uf_err", 32'(b_err), 32'h1);
    b_err_clr = 1;
    tick();
    b_err_clr = 0;
    check_eq("nb_clr_err", 32'(b_err), 32'h0);
    b_err_clr = 1; b_req_in = 1;
    tick();
    b_err_clr = 0; b_req_in = 0;
    check_eq("nb_set_wins", 32'(b_err), 32'h1);
    b_err_clr = 1;
    tick();
    b_err_clr = 0;

    // Non-blocking overflow: 5th write dropped, no stall
    b_out_en = 1; b_addr_out = 3'd0;
    for (int i = 0; i < 5; i++) begin
      b_io_out = wr_words[i];
      #1;
      check_eq($sformatf("nb_wr%0d_stall", i), 32'(b_stall), 32'h0);
      tick();
    end
    b_out_en = 0;
    check_eq("nb_of_err", 32'(b_err), 32'h2);
    check_eq("nb_of_head", 32'(b_m_data[15:0]), 32'h0011);
    b_err_clr = 1;
    tick();
    b_err_clr = 0;

    // Out-of-range read address leaves channels untouched
    b_s_valid = 6'h04; b_s_data[2*16 +: 16] = 16'hC0DE;
    tick();
    b_s_valid = 0;
    b_req_in = 1; b_addr_in = 3'd7;
    #1;
    check_eq("oob_io_in", 32'(b_io_in), 32'h0);
    check_eq("oob_stall", 32'(b_stall), 32'h0);
    tick();
    b_req_in = 0;
    check_eq("oob_err", 32'(b_err), 32'h4);
    b_req_in = 1; b_addr_in = 3'd2;
    #1;
    check_eq("oob_ch2_kept", 32'(b_io_in), 32'hC0DE);
    tick();
    b_req_in = 0;
    check_eq("oob_ch2_popped_err", 32'(b_err), 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
